// File: rtl/rv32_pkg.sv
// Shared RV32I write-back definitions: widths, register index type, state and requester ids.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32_pkg;

  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NREG = 32;

  typedef logic [AW-1:0] reg_idx_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } wb_state_e;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; on contention grants the requester that did not win last.
// Latency: grants are combinational; rr_last updates on the edge of each grant.
// Backpressure: a requester not granted keeps its request up; en=0 withholds all grants.
// Ports: clk/clrn (async active-high reset), en, a_req/b_req in, a_gnt/b_gnt out.
module rr_arb2
  import rv32_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic en,
  input  logic a_req,
  input  logic b_req,
  output logic a_gnt,
  output logic b_gnt
);

  req_id_e rr_last;

  always_comb begin
    a_gnt = 1'b0;
    b_gnt = 1'b0;
    if (en) begin
      if (a_req && b_req) begin
        a_gnt = (rr_last == REQ_B);
        b_gnt = (rr_last == REQ_A);
      end else begin
        a_gnt = a_req;
        b_gnt = b_req;
      end
    end
  end

  // Starting from B means A wins the first contended cycle after reset.
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      rr_last <= REQ_B;
    end else if (a_gnt) begin
      rr_last <= REQ_A;
    end else if (b_gnt) begin
      rr_last <= REQ_B;
    end
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Register-file write-back controller: zeroes x1..x31 after reset, then arbitrates ALU (A) and
// load (B) writers onto the single write port and tracks pending writes for RAW hazard queries.
// Latency: grant same cycle; wreg/wr/wd one cycle after the handshake. Backpressure: the loser holds its request.
// Ports: clk, clrn (async active-high), init_busy; a_*/b_* requesters; rsv_* reserve; q_* hazard query; wreg/wr/wd to regfile.
module regfile_wb_ctrl
  import rv32_pkg::*;
(
  input  logic            clk,
  input  logic            clrn,
  output logic            init_busy,
  input  logic            a_req,
  input  logic [AW-1:0]   a_wr,
  input  logic [XLEN-1:0] a_wd,
  output logic            a_gnt,
  input  logic            b_req,
  input  logic [AW-1:0]   b_wr,
  input  logic [XLEN-1:0] b_wd,
  output logic            b_gnt,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_reg,
  input  logic [AW-1:0]   q_rs1,
  input  logic [AW-1:0]   q_rs2,
  output logic            q_hz1,
  output logic            q_hz2,
  output logic            wreg,
  output logic [AW-1:0]   wr,
  output logic [XLEN-1:0] wd
);

  wb_state_e       state;
  reg_idx_t        idx;
  logic [NREG-1:0] pending;
  logic [NREG-1:0] pend_nxt;

  assign init_busy = (state == ST_INIT);

  rr_arb2 u_arb (
    .clk   (clk),
    .clrn  (clrn),
    .en    (state == ST_RUN),
    .a_req (a_req),
    .b_req (b_req),
    .a_gnt (a_gnt),
    .b_gnt (b_gnt)
  );

  // No bypass: a hazard stays visible through the commit cycle itself.
  assign q_hz1 = pending[q_rs1];
  assign q_hz2 = pending[q_rs2];

  // Clear on commit first, then set, so a reservation landing on the commit edge survives.
  always_comb begin
    pend_nxt = pending;
    if (wreg) begin
      pend_nxt[wr] = 1'b0;
    end
    if ((state == ST_RUN) && rsv_valid && (rsv_reg != '0)) begin
      pend_nxt[rsv_reg] = 1'b1;
    end
    pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state   <= ST_INIT;
      idx     <= reg_idx_t'(1);
      pending <= '0;
      wreg    <= 1'b0;
      wr      <= '0;
      wd      <= '0;
    end else begin
      pending <= pend_nxt;
      case (state)
        ST_INIT: begin
          wreg <= 1'b1;
          wr   <= idx;
          wd   <= '0;
          idx  <= idx + reg_idx_t'(1);
          if (idx == reg_idx_t'(NREG - 1)) begin
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A granted write to x0 completes the handshake but never reaches the regfile.
          wreg <= 1'b0;
          if (a_gnt && (a_wr != '0)) begin
            wreg <= 1'b1;
            wr   <= a_wr;
            wd   <= a_wd;
          end else if (b_gnt && (b_wr != '0)) begin
            wreg <= 1'b1;
            wr   <= b_wr;
            wd   <= b_wd;
          end
        end
        default: begin
          state <= ST_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;

  logic        clk;
  logic        clrn;
  logic        init_busy;
  logic        a_req;
  logic [4:0]  a_wr;
  logic [31:0] a_wd;
  logic        a_gnt;
  logic        b_req;
  logic [4:0]  b_wr;
  logic [31:0] b_wd;
  logic        b_gnt;
  logic        rsv_valid;
  logic [4:0]  rsv_reg;
  logic [4:0]  q_rs1;
  logic [4:0]  q_rs2;
  logic        q_hz1;
  logic        q_hz2;
  logic        wreg;
  logic [4:0]  wr;
  logic [31:0] wd;

  int n_cmp = 0;
  int n_err = 0;

  regfile_wb_ctrl dut (
    .clk       (clk),
    .clrn      (clrn),
    .init_busy (init_busy),
    .a_req     (a_req),
    .a_wr      (a_wr),
    .a_wd      (a_wd),
    .a_gnt     (a_gnt),
    .b_req     (b_req),
    .b_wr      (b_wr),
    .b_wd      (b_wd),
    .b_gnt     (b_gnt),
    .rsv_valid (rsv_valid),
    .rsv_reg   (rsv_reg),
    .q_rs1     (q_rs1),
    .q_rs2     (q_rs2),
    .q_hz1     (q_hz1),
    .q_hz2     (q_hz2),
    .wreg      (wreg),
    .wr        (wr),
    .wd        (wd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        a_req;
    logic        b_req;
    logic [4:0]  a_wr;
    logic [4:0]  b_wr;
    logic [31:0] a_wd;
    logic [31:0] b_wd;
    logic        e_ag;
    logic        e_bg;
    logic        e_wreg;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expects to start with reset just released while clk is low.
  task automatic init_seq();
    chk("init_busy_start", init_busy, 1);
    chk("init_wreg_start", wreg, 0);
    for (int k = 1; k <= 31; k++) begin
      @(posedge clk); #1;
      chk("init_wreg", wreg, 1);
      chk("init_wr", wr, k);
      chk("init_wd", wd, 0);
      chk("init_busy", init_busy, (k < 31) ? 1 : 0);
      if (k < 31) chk("init_a_gnt", a_gnt, 0);
      if (k == 30) a_req = 1'b0;
    end
  endtask

  // Behavioural model state for the random phase.
  bit          pend [32];
  bit          m_last_b;
  bit          m_wreg;
  logic [4:0]  m_wr;
  logic [31:0] m_wd;
  bit          a_hold;
  bit          b_hold;
  bit          eg_a;
  bit          eg_b;
  bit          n_wreg;

  initial begin
    tbl[0] = '{1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    tbl[1] = '{1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1, 5'd4, 32'h22};
    tbl[2] = '{1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    tbl[3] = '{1'b1, 1'b1, 5'd3, 5'd4, 32'h11, 32'h22, 1'b0, 1'b1, 1'b1, 5'd4, 32'h22};
    tbl[4] = '{1'b1, 1'b0, 5'd5, 5'd4, 32'hDEADBEEF, 32'h22, 1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    tbl[5] = '{1'b0, 1'b0, 5'd8, 5'd8, 32'h1, 32'h2, 1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF};
    tbl[6] = '{1'b0, 1'b1, 5'd8, 5'd9, 32'h1, 32'h12345678, 1'b0, 1'b1, 1'b1, 5'd9, 32'h12345678};
    tbl[7] = '{1'b1, 1'b0, 5'd0, 5'd9, 32'hFFFFFFFF, 32'h0, 1'b1, 1'b0, 1'b0, 5'd9, 32'h12345678};
    tbl[8] = '{1'b1, 1'b1, 5'd1, 5'd10, 32'h5555, 32'hCAFE0001, 1'b0, 1'b1, 1'b1, 5'd10, 32'hCAFE0001};
    tbl[9] = '{1'b1, 1'b0, 5'd1, 5'd10, 32'h5555, 32'h0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h5555};

    clrn = 1'b1;
    a_req = 1'b1; a_wr = 5'd2; a_wd = 32'h0;
    b_req = 1'b0; b_wr = 5'd0; b_wd = 32'h0;
    rsv_valid = 1'b0; rsv_reg = 5'd0; q_rs1 = 5'd0; q_rs2 = 5'd0;

    #2;
    chk("rst_wreg", wreg, 0);
    chk("rst_busy", init_busy, 1);
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_hz1", q_hz1, 0);
    repeat (2) @(negedge clk);
    clrn = 1'b0;

    init_seq();

    // Table-driven arbitration and write-latency vectors.
    for (int i = 0; i < 10; i++) begin
      a_req = tbl[i].a_req; a_wr = tbl[i].a_wr; a_wd = tbl[i].a_wd;
      b_req = tbl[i].b_req; b_wr = tbl[i].b_wr; b_wd = tbl[i].b_wd;
      #1;
      chk("tbl_a_gnt", a_gnt, tbl[i].e_ag);
      chk("tbl_b_gnt", b_gnt, tbl[i].e_bg);
      @(posedge clk); #1;
      chk("tbl_wreg", wreg, tbl[i].e_wreg);
      chk("tbl_wr", wr, tbl[i].e_wr);
      chk("tbl_wd", wd, tbl[i].e_wd);
    end
    a_req = 1'b0; b_req = 1'b0;
    @(posedge clk); #1;
    chk("idle_wreg", wreg, 0);

    // Scoreboard: reserve x7, commit via B, hazard drops the cycle after commit.
    q_rs1 = 5'd7; q_rs2 = 5'd0;
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    #1;
    chk("hz1_before_rsv", q_hz1, 0);
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    chk("hz1_after_rsv", q_hz1, 1);
    repeat (2) begin
      @(posedge clk); #1;
      chk("hz1_hold", q_hz1, 1);
    end
    b_req = 1'b1; b_wr = 5'd7; b_wd = 32'h77;
    #1;
    chk("sb_b_gnt", b_gnt, 1);
    @(posedge clk); #1;
    b_req = 1'b0;
    chk("sb_commit_wreg", wreg, 1);
    chk("sb_commit_wr", wr, 7);
    chk("hz1_commit_cycle", q_hz1, 1);
    @(posedge clk); #1;
    chk("hz1_after_commit", q_hz1, 0);

    // Re-reserve on the commit edge: set wins.
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    chk("hz1_rsv2", q_hz1, 1);
    b_req = 1'b1; b_wr = 5'd7; b_wd = 32'h88;
    @(posedge clk); #1;
    b_req = 1'b0;
    chk("sw_commit_wr", wr, 7);
    chk("sw_commit_wreg", wreg, 1);
    rsv_valid = 1'b1; rsv_reg = 5'd7;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    chk("hz1_set_wins", q_hz1, 1);
    @(posedge clk); #1;
    chk("hz1_set_wins_hold", q_hz1, 1);

    // x0 reservation is ignored.
    rsv_valid = 1'b1; rsv_reg = 5'd0; q_rs2 = 5'd0;
    @(posedge clk); #1;
    rsv_valid = 1'b0;
    chk("hz2_x0", q_hz2, 0);

    // Reset during RUN with a write in flight.
    a_req = 1'b1; a_wr = 5'd6; a_wd = 32'hAAAA5555;
    @(posedge clk); #1;
    a_req = 1'b0;
    chk("mid_inflight_wreg", wreg, 1);
    chk("mid_inflight_wr", wr, 6);
    chk("mid_hz1_pre", q_hz1, 1);
    #1;
    clrn = 1'b1;
    #1;
    chk("mid_rst_wreg", wreg, 0);
    chk("mid_rst_hz1", q_hz1, 0);
    chk("mid_rst_busy", init_busy, 1);
    @(posedge clk);
    @(negedge clk);
    clrn = 1'b0;
    a_req = 1'b1;
    init_seq();

    // Random phase against a behavioural model.
    for (int r = 0; r < 32; r++) pend[r] = 1'b0;
    m_last_b = 1'b1;
    m_wreg = 1'b1; m_wr = 5'd31; m_wd = 32'h0;
    a_hold = 1'b0; b_hold = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_hold) begin
        a_req = 1'($urandom_range(0, 1));
        a_wr  = 5'($urandom_range(0, 31));
        a_wd  = $urandom;
      end
      if (!b_hold) begin
        b_req = 1'($urandom_range(0, 1));
        b_wr  = 5'($urandom_range(0, 31));
        b_wd  = $urandom;
      end
      rsv_valid = ($urandom_range(0, 3) == 0);
      rsv_reg   = 5'($urandom_range(0, 31));
      q_rs1     = 5'($urandom_range(0, 31));
      q_rs2     = 5'($urandom_range(0, 31));
      eg_a = a_req && (!b_req || m_last_b);
      eg_b = b_req && (!a_req || !m_last_b);
      #1;
      chk("rnd_a_gnt", a_gnt, eg_a);
      chk("rnd_b_gnt", b_gnt, eg_b);
      chk("rnd_hz1", q_hz1, pend[q_rs1]);
      chk("rnd_hz2", q_hz2, pend[q_rs2]);
      if (m_wreg) pend[m_wr] = 1'b0;
      if (rsv_valid && rsv_reg != 5'd0) pend[rsv_reg] = 1'b1;
      n_wreg = 1'b0;
      if (eg_a) begin
        m_last_b = 1'b0;
        if (a_wr != 5'd0) begin n_wreg = 1'b1; m_wr = a_wr; m_wd = a_wd; end
      end else if (eg_b) begin
        m_last_b = 1'b1;
        if (b_wr != 5'd0) begin n_wreg = 1'b1; m_wr = b_wr; m_wd = b_wd; end
      end
      m_wreg = n_wreg;
      a_hold = a_req && !eg_a;
      b_hold = b_req && !eg_b;
      @(posedge clk); #1;
      chk("rnd_wreg", wreg, m_wreg);
      chk("rnd_wr", wr, m_wr);
      chk("rnd_wd", wd, m_wd);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
